// File: rtl/phy_free_list_pkg.sv
// Shared sizing and types for the physical register free list.
package phy_free_list_pkg;
  localparam int NUM_PHY_REGS = 64;
  localparam int ARCH_REGS    = 32;
  localparam int PHY_WIDTH    = $clog2(NUM_PHY_REGS);
  localparam int FL_DEPTH     = NUM_PHY_REGS - ARCH_REGS;
  localparam int IDX_W        = $clog2(FL_DEPTH);
  localparam int PTR_W        = IDX_W + 1;

  typedef logic [PHY_WIDTH-1:0] phy_tag_t;
  typedef logic [PTR_W-1:0]     fl_ptr_t;
  typedef logic [IDX_W-1:0]     fl_idx_t;

  // Number of active lanes in a 2-lane valid vector, sized for pointer math.
  function automatic fl_ptr_t pop2(input logic [1:0] v);
    return fl_ptr_t'(v[0]) + fl_ptr_t'(v[1]);
  endfunction
endpackage

// File: rtl/phy_free_list_if.sv
// Rename/commit-side bundle of the free list: alloc peek, commit and release.
interface phy_free_list_if;
  import phy_free_list_pkg::*;

  logic       flush;
  logic [1:0] alloc_req;
  logic       alloc_ok;
  phy_tag_t   alloc_phy_0;
  phy_tag_t   alloc_phy_1;
  logic [1:0] commit_valid;
  logic [1:0] rel_valid;
  phy_tag_t   rel_phy_0;
  phy_tag_t   rel_phy_1;
  fl_ptr_t    free_count;

  modport master (
    output flush, alloc_req, commit_valid, rel_valid, rel_phy_0, rel_phy_1,
    input  alloc_ok, alloc_phy_0, alloc_phy_1, free_count
  );
  modport slave (
    input  flush, alloc_req, commit_valid, rel_valid, rel_phy_0, rel_phy_1,
    output alloc_ok, alloc_phy_0, alloc_phy_1, free_count
  );
endinterface

// File: rtl/phy_free_list_mem.sv
// 2-write / 2-read tag storage. Reset image holds tags ARCH_REGS..NUM_PHY_REGS-1.
// Reads are combinational from the registered array, so a write is seen next cycle.
module phy_free_list_mem
  import phy_free_list_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic     [1:0]     we,
  input  fl_idx_t  [1:0]     waddr,
  input  phy_tag_t [1:0]     wdata,
  input  fl_idx_t  [1:0]     raddr,
  output phy_tag_t [1:0]     rdata
);
  phy_tag_t [FL_DEPTH-1:0] mem_q, mem_d;

  // Apply both write ports; port 1 wins only if addresses collide (never in practice).
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < 2; w++)
      if (we[w]) mem_d[waddr[w]] = wdata[w];
  end

  // Storage register with the reset image of unmapped tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) mem_q[i] <= phy_tag_t'(ARCH_REGS + i);
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar r = 0; r < 2; r++) begin : g_rd
    assign rdata[r] = mem_q[raddr[r]];
  end
endmodule

// File: rtl/phy_free_list.sv
// Circular free list of physical register tags feeding rename.
// Speculative head (alloc), arch head (commit) and tail (release) each carry a wrap bit.
// Optional simulation checks: define FREE_LIST_CHECK_EN.
module phy_free_list
  import phy_free_list_pkg::*;
(
  input logic            clk,
  input logic            rst,
  phy_free_list_if.slave fl
);
  fl_ptr_t head_q, head_d, arch_head_q, arch_head_d, tail_q, tail_d;
  fl_ptr_t n_alloc, n_com, n_rel, free_cnt;
  fl_idx_t head_idx, tail_idx;
  logic    alloc_ok;

  logic     [1:0] we;
  fl_idx_t  [1:0] waddr, raddr;
  phy_tag_t [1:0] wdata, rdata;

  assign n_alloc  = pop2(fl.alloc_req);
  assign n_com    = pop2(fl.commit_valid);
  assign n_rel    = pop2(fl.rel_valid);
  assign free_cnt = tail_q - head_q;
  assign alloc_ok = free_cnt >= n_alloc;
  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  // Compacted peek: slot1 takes the next tag only when slot0 also consumes one.
  assign raddr[0] = head_idx;
  assign raddr[1] = fl.alloc_req[0] ? head_idx + fl_idx_t'(1) : head_idx;

  // Compacted release: first active lane lands at tail, second at tail+1.
  assign we[0]    = |fl.rel_valid;
  assign we[1]    = &fl.rel_valid;
  assign waddr[0] = tail_idx;
  assign waddr[1] = tail_idx + fl_idx_t'(1);
  assign wdata[0] = fl.rel_valid[0] ? fl.rel_phy_0 : fl.rel_phy_1;
  assign wdata[1] = fl.rel_phy_1;

  phy_free_list_mem u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign fl.alloc_ok    = alloc_ok;
  assign fl.alloc_phy_0 = rdata[0];
  assign fl.alloc_phy_1 = rdata[1];
  assign fl.free_count  = free_cnt;

  // Pointer update: flush rewinds head to the post-commit arch head, else all-or-nothing grant.
  always_comb begin
    arch_head_d = arch_head_q + n_com;
    tail_d      = tail_q + n_rel;
    head_d      = head_q;
    if (fl.flush)     head_d = arch_head_d;
    else if (alloc_ok) head_d = head_q + n_alloc;
  end

  // Pointer registers; tail starts one full lap ahead so the list begins full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= fl_ptr_t'(FL_DEPTH);
    end else begin
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
    end
  end

`ifdef FREE_LIST_CHECK_EN
  fl_ptr_t occ;
  assign occ = tail_q - arch_head_q;

  // Pointer-relationship checks on the next state.
  always @(posedge clk) begin
    if (!rst) begin
      if (fl_ptr_t'(tail_d - arch_head_d) > fl_ptr_t'(FL_DEPTH))
        $error("free list overflow: tail-arch_head exceeds depth");
      if (fl_ptr_t'(head_d - arch_head_d) > fl_ptr_t'(FL_DEPTH))
        $error("free list arch_head passed head");
      if (occ == fl_ptr_t'(FL_DEPTH) &&
          ((fl.rel_valid[0] && fl.rel_phy_0 < phy_tag_t'(ARCH_REGS)) ||
           (fl.rel_valid[1] && fl.rel_phy_1 < phy_tag_t'(ARCH_REGS))))
        $error("free list release of low tag while full");
    end
  end

  // Every tag between arch head and tail must be unique.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FL_DEPTH; i++)
        for (int j = i + 1; j < FL_DEPTH; j++)
          if (j < int'(occ) &&
              u_mem.mem_q[fl_idx_t'(int'(arch_head_q[IDX_W-1:0]) + i)] ==
              u_mem.mem_q[fl_idx_t'(int'(arch_head_q[IDX_W-1:0]) + j)])
            $error("free list duplicate tag");
    end
  end
`endif
endmodule

// File: tb/tb_phy_free_list.sv
// Bench for phy_free_list: directed scenarios against fixed tags, then a random run
// checked against a queue model (free list / in-flight / mapped pools).
module tb_phy_free_list;
  import phy_free_list_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phy_free_list_if fl_if();
  phy_free_list u_dut (.clk(clk), .rst(rst), .fl(fl_if.slave));

  typedef struct {
    logic     ok;
    fl_ptr_t  cnt;
    phy_tag_t p0, p1;
    logic     c0, c1;
  } exp_t;

  exp_t     exp_q[$];
  phy_tag_t free_m[$], infl_m[$], mapped_m[$];
  int n_cmp = 0, n_err = 0;

  task automatic model_reset();
    free_m.delete(); infl_m.delete(); mapped_m.delete(); exp_q.delete();
    for (int i = 0; i < FL_DEPTH; i++) free_m.push_back(phy_tag_t'(ARCH_REGS + i));
    for (int i = 0; i < ARCH_REGS; i++) mapped_m.push_back(phy_tag_t'(i));
  endtask

  task automatic model_release(input phy_tag_t t);
    int idx[$];
    free_m.push_back(t);
    idx = mapped_m.find_first_index(x) with (x == t);
    if (idx.size() > 0) mapped_m.delete(idx[0]);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    fl_if.flush = 1'b0; fl_if.alloc_req = '0; fl_if.commit_valid = '0;
    fl_if.rel_valid = '0; fl_if.rel_phy_0 = '0; fl_if.rel_phy_1 = '0;
    model_reset();
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one cycle at negedge, push the model expectation, then advance the model.
  task automatic drive(input logic [1:0] req, input logic [1:0] com, input logic [1:0] relv,
                       input phy_tag_t r0, input phy_tag_t r1, input logic fls);
    exp_t e;
    int na, nc;
    @(negedge clk);
    fl_if.alloc_req = req; fl_if.commit_valid = com; fl_if.rel_valid = relv;
    fl_if.rel_phy_0 = r0; fl_if.rel_phy_1 = r1; fl_if.flush = fls;
    na = int'(req[0]) + int'(req[1]);
    nc = int'(com[0]) + int'(com[1]);
    e.ok  = free_m.size() >= na;
    e.cnt = fl_ptr_t'(free_m.size());
    e.c0  = e.ok && req[0];
    e.c1  = e.ok && req[1];
    e.p0  = (free_m.size() > 0) ? free_m[0] : '0;
    if (req[0]) e.p1 = (free_m.size() > 1) ? free_m[1] : '0;
    else        e.p1 = e.p0;
    exp_q.push_back(e);
    for (int i = 0; i < nc; i++) if (infl_m.size() > 0) mapped_m.push_back(infl_m.pop_front());
    if (fls) begin
      for (int i = infl_m.size() - 1; i >= 0; i--) free_m.push_front(infl_m[i]);
      infl_m.delete();
    end else if (e.ok) begin
      for (int i = 0; i < na; i++) infl_m.push_back(free_m.pop_front());
    end
    if (relv[0]) model_release(r0);
    if (relv[1]) model_release(r1);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    drive(2'b00, 2'b00, 2'b00, '0, '0, 1'b0);
    n_cmp++; if (fl_if.free_count !== 6'd32) begin n_err++; $display("FAIL reset_count: got %0d want 32", fl_if.free_count); end
    n_cmp++; if (fl_if.alloc_ok !== 1'b1) begin n_err++; $display("FAIL reset_ok_idle: got %0b want 1", fl_if.alloc_ok); end
    drive(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    n_cmp++; if (fl_if.alloc_ok !== 1'b1) begin n_err++; $display("FAIL reset_ok: got %0b want 1", fl_if.alloc_ok); end
    n_cmp++; if (fl_if.alloc_phy_0 !== 6'd32 || fl_if.alloc_phy_1 !== 6'd33) begin n_err++;
      $display("FAIL first_tags: got %0d,%0d want 32,33", fl_if.alloc_phy_0, fl_if.alloc_phy_1); end
    drive(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    n_cmp++; if (fl_if.alloc_phy_0 !== 6'd34 || fl_if.alloc_phy_1 !== 6'd35) begin n_err++;
      $display("FAIL second_tags: got %0d,%0d want 34,35", fl_if.alloc_phy_0, fl_if.alloc_phy_1); end
    n_cmp++; if (fl_if.free_count !== 6'd30) begin n_err++; $display("FAIL count_30: got %0d want 30", fl_if.free_count); end
    drive(2'b00, 2'b00, 2'b00, '0, '0, 1'b0);
    n_cmp++; if (fl_if.free_count !== 6'd28) begin n_err++; $display("FAIL count_28: got %0d want 28", fl_if.free_count); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 13; i++) drive(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    drive(2'b01, 2'b00, 2'b00, '0, '0, 1'b0);
    drive(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    n_cmp++; if (fl_if.free_count !== 6'd1) begin n_err++; $display("FAIL drain_count1: got %0d want 1", fl_if.free_count); end
    n_cmp++; if (fl_if.alloc_ok !== 1'b0) begin n_err++; $display("FAIL short_ok: got %0b want 0", fl_if.alloc_ok); end
    drive(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    n_cmp++; if (fl_if.free_count !== 6'd1 || fl_if.alloc_phy_0 !== 6'd63) begin n_err++;
      $display("FAIL stall_hold: got count %0d tag %0d want 1,63", fl_if.free_count, fl_if.alloc_phy_0); end
    drive(2'b01, 2'b00, 2'b00, '0, '0, 1'b0);
    n_cmp++; if (fl_if.alloc_ok !== 1'b1 || fl_if.alloc_phy_0 !== 6'd63) begin n_err++;
      $display("FAIL last_tag: got ok %0b tag %0d want 1,63", fl_if.alloc_ok, fl_if.alloc_phy_0); end
    drive(2'b00, 2'b00, 2'b00, '0, '0, 1'b0);
    n_cmp++; if (fl_if.free_count !== 6'd0 || fl_if.alloc_ok !== 1'b1) begin n_err++;
      $display("FAIL empty_idle: got count %0d ok %0b want 0,1", fl_if.free_count, fl_if.alloc_ok); end
    drive(2'b01, 2'b00, 2'b00, '0, '0, 1'b0);
    n_cmp++; if (fl_if.alloc_ok !== 1'b0) begin n_err++; $display("FAIL empty_ok: got %0b want 0", fl_if.alloc_ok); end
  endtask

  task automatic test_flush_restore();
    apply_reset();
    drive(2'b00, 2'b00, 2'b00, '0, '0, 1'b0);
    n_cmp++; if (fl_if.free_count !== 6'd32 || fl_if.alloc_phy_0 !== 6'd32) begin n_err++;
      $display("FAIL midrun_reset: got count %0d tag %0d want 32,32", fl_if.free_count, fl_if.alloc_phy_0); end
    drive(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    drive(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    drive(2'b00, 2'b11, 2'b00, '0, '0, 1'b0);
    drive(2'b11, 2'b00, 2'b00, '0, '0, 1'b1);
    drive(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    n_cmp++; if (fl_if.free_count !== 6'd30) begin n_err++; $display("FAIL flush_count: got %0d want 30", fl_if.free_count); end
    n_cmp++; if (fl_if.alloc_phy_0 !== 6'd34 || fl_if.alloc_phy_1 !== 6'd35) begin n_err++;
      $display("FAIL flush_tags: got %0d,%0d want 34,35", fl_if.alloc_phy_0, fl_if.alloc_phy_1); end
    drive(2'b10, 2'b00, 2'b00, '0, '0, 1'b0);
    n_cmp++; if (fl_if.alloc_ok !== 1'b1 || fl_if.alloc_phy_1 !== 6'd36) begin n_err++;
      $display("FAIL compact_slot1: got ok %0b tag %0d want 1,36", fl_if.alloc_ok, fl_if.alloc_phy_1); end
  endtask

  task automatic test_release();
    apply_reset();
    drive(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    for (int i = 0; i < 15; i++) drive(2'b11, 2'b11, 2'b00, '0, '0, 1'b0);
    drive(2'b00, 2'b11, 2'b00, '0, '0, 1'b0);
    drive(2'b11, 2'b00, 2'b11, 6'd5, 6'd7, 1'b0);
    n_cmp++; if (fl_if.free_count !== 6'd0 || fl_if.alloc_ok !== 1'b0) begin n_err++;
      $display("FAIL no_bypass: got count %0d ok %0b want 0,0", fl_if.free_count, fl_if.alloc_ok); end
    drive(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    n_cmp++; if (fl_if.free_count !== 6'd2) begin n_err++; $display("FAIL rel_count: got %0d want 2", fl_if.free_count); end
    n_cmp++; if (fl_if.alloc_ok !== 1'b1 || fl_if.alloc_phy_0 !== 6'd5 || fl_if.alloc_phy_1 !== 6'd7) begin n_err++;
      $display("FAIL rel_tags: got ok %0b %0d,%0d want 1,5,7", fl_if.alloc_ok, fl_if.alloc_phy_0, fl_if.alloc_phy_1); end
  endtask

  task automatic test_flush_release();
    drive(2'b11, 2'b01, 2'b01, 6'd9, 6'd0, 1'b1);
    drive(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    n_cmp++; if (fl_if.free_count !== 6'd2) begin n_err++; $display("FAIL flrel_count: got %0d want 2", fl_if.free_count); end
    n_cmp++; if (fl_if.alloc_phy_0 !== 6'd7 || fl_if.alloc_phy_1 !== 6'd9) begin n_err++;
      $display("FAIL flrel_tags: got %0d,%0d want 7,9", fl_if.alloc_phy_0, fl_if.alloc_phy_1); end
  endtask

  task automatic test_random();
    exp_t e;
    logic [1:0] req, com, relv;
    phy_tag_t r0, r1, t0, t1;
    int ncm, room, nr, a, b, ms;
    apply_reset();
    for (int cyc = 0; cyc < 200; cyc++) begin
      req = 2'($urandom_range(0, 3));
      ncm = $urandom_range(0, (infl_m.size() < 2) ? infl_m.size() : 2);
      com = (ncm == 2) ? 2'b11 : (ncm == 1) ? ($urandom_range(0, 1) ? 2'b01 : 2'b10) : 2'b00;
      room = FL_DEPTH - free_m.size() - infl_m.size();
      nr = $urandom_range(0, (room < 2) ? room : 2);
      ms = mapped_m.size();
      a = $urandom_range(0, ms - 1);
      b = (a + 1 + $urandom_range(0, ms - 2)) % ms;
      t0 = mapped_m[a]; t1 = mapped_m[b];
      r0 = phy_tag_t'($urandom_range(0, 63)); r1 = phy_tag_t'($urandom_range(0, 63));
      relv = 2'b00;
      if (nr == 2) begin relv = 2'b11; r0 = t0; r1 = t1; end
      else if (nr == 1) begin
        if ($urandom_range(0, 1) != 0) begin relv = 2'b01; r0 = t0; end
        else begin relv = 2'b10; r1 = t0; end
      end
      drive(req, com, relv, r0, r1, ($urandom_range(0, 15) == 0));
      e = exp_q.pop_front();
      n_cmp++; if (fl_if.alloc_ok !== e.ok || fl_if.free_count !== e.cnt) begin n_err++;
        $display("FAIL rnd_ok_count cyc %0d: got ok %0b count %0d want ok %0b count %0d",
                 cyc, fl_if.alloc_ok, fl_if.free_count, e.ok, e.cnt); end
      if (e.c0) begin n_cmp++; if (fl_if.alloc_phy_0 !== e.p0) begin n_err++;
        $display("FAIL rnd_tag0 cyc %0d: got %0d want %0d", cyc, fl_if.alloc_phy_0, e.p0); end end
      if (e.c1) begin n_cmp++; if (fl_if.alloc_phy_1 !== e.p1) begin n_err++;
        $display("FAIL rnd_tag1 cyc %0d: got %0d want %0d", cyc, fl_if.alloc_phy_1, e.p1); end end
    end
    drive(2'b00, 2'b00, 2'b00, '0, '0, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (fl_if.free_count !== e.cnt) begin n_err++;
      $display("FAIL rnd_final_count: got %0d want %0d", fl_if.free_count, e.cnt); end
  endtask

  initial begin
    fl_if.flush = 1'b0; fl_if.alloc_req = '0; fl_if.commit_valid = '0;
    fl_if.rel_valid = '0; fl_if.rel_phy_0 = '0; fl_if.rel_phy_1 = '0;
    test_reset();
    test_drain();
    test_flush_restore();
    test_release();
    test_flush_release();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
